// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: op encodings, FSM states and default width for the multiply/divide unit
package mul_div_unit_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;
  typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_e;
endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one shift-add multiply step or one restoring divide step on the 2*WIDTH+1-bit accumulator
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             div,
  output logic [2*WIDTH:0] next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
  logic           ge;
  // multiply: {carry,high} += operand when the multiplier lsb is set, then shift right;
  // divide: shift the next dividend bit into the remainder and subtract when it fits
  always_comb begin
    sum  = acc[2*WIDTH:WIDTH] + {1'b0, operand & {WIDTH{acc[0]}}};
    rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rem - {1'b0, operand};
    ge   = rem >= {1'b0, operand};
    next = div ? {ge ? diff : rem, acc[WIDTH-2:0], ge} : {1'b0, sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO registers
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e state, next_state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   acc, acc_next;
  logic [WIDTH-1:0]   b_reg;
  logic               is_div, neg_q, neg_r;
  logic               accept, md_accept, last, sgn, s1, s2;
  logic [WIDTH-1:0]   a_mag, b_mag, q, r, q_s, r_s, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_s;
  assign busy = state != IDLE;
  // acceptance and magnitude conversion of the signed operands
  always_comb begin
    accept    = start & (state == IDLE) & ~cancel;
    md_accept = accept & ~op[2];
    last      = cnt == CW'(WIDTH - 1);
    sgn       = ~op[0];
    s1        = sgn & opr1[WIDTH-1];
    s2        = sgn & opr2[WIDTH-1];
    a_mag     = s1 ? -opr1 : opr1;
    b_mag     = s2 ? -opr2 : opr2;
  end
  // sign correction of the finished iteration; a zero divisor forces an all-ones quotient
  always_comb begin
    prod_s = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    q      = acc[WIDTH-1:0];
    r      = acc[2*WIDTH-1:WIDTH];
    q_s    = (b_reg == '0) ? '1 : neg_q ? -q : q;
    r_s    = neg_r ? -r : r;
    res_hi = is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
    res_lo = is_div ? q_s : prod_s[WIDTH-1:0];
  end
  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .acc(acc),
    .operand(b_reg),
    .div(is_div),
    .next(acc_next)
  );
  // FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next_state;
  // next state: cancel always returns to IDLE
  always_comb begin
    next_state = IDLE;
    if (!cancel)
      next_state = state == IDLE ? (md_accept ? RUN : IDLE) : state == RUN ? (last ? FIX : RUN) : IDLE;
  end
  // datapath: operand latch, iteration, HI/LO writes and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      b_reg  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (md_accept) begin
        acc    <= {{(WIDTH+1){1'b0}}, a_mag};
        b_reg  <= b_mag;
        is_div <= op[1];
        neg_q  <= s1 ^ s2;
        neg_r  <= s1;
        cnt    <= '0;
      end else if (cancel) begin
        cnt <= '0;
      end else if (state == RUN) begin
        acc <= acc_next;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (state == FIX && !cancel) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end
      if (accept && op == MDU_MTHI) hi <= opr1;
      if (accept && op == MDU_MTLO) lo <= opr1;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus hand sequences for the multi-cycle corner cases
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;
  logic        clk = 0, reset = 1, start = 0, cancel = 0;
  logic [2:0]  op = 3'b111;
  logic [31:0] opr1 = 0, opr2 = 0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int applied = 0, miscompares = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
    string       name;
  } vec_t;
  vec_t vecs[14];

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int n;
    @(negedge clk); op = o; opr1 = a; opr2 = b; start = 1;
    @(negedge clk); start = 0; opr1 = 32'hdeadbeef; opr2 = 32'h5a5a5a5a;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    chk({nm, " busy cycles"}, 32'(n), 32'd33);
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    @(negedge clk);
    chk({nm, " done pulse once"}, 32'(done), 32'd0);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk); op = o; opr1 = v; start = 1;
    @(negedge clk); start = 0;
  endtask

  initial begin
    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7"};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
    vecs[3]  = '{MDU_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, "divu 7/0"};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div min/-1"};
    vecs[5]  = '{MDU_MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       "multu 6*7"};
    vecs[6]  = '{MDU_DIVU,  32'd100,      32'd3,        32'd1,        32'd33,       "divu 100/3"};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div 7/-2"};
    vecs[8]  = '{MDU_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div -7/0"};
    vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        "mult min*min"};
    vecs[10] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        "mult -1*-1"};
    vecs[11] = '{MDU_MULT,  32'h12345678, 32'd0,        32'd0,        32'd0,        "mult by 0"};
    vecs[12] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "divu max/1"};
    vecs[13] = '{MDU_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        "multu 2^16^2"};

    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].name);

    @(negedge clk); op = MDU_MTHI; opr1 = 32'h1234; start = 1;
    @(negedge clk); op = MDU_MTLO; opr1 = 32'h5678;
    chk("mthi busy", 32'(busy), 0);
    chk("mthi hi", hi, 32'h1234);
    @(negedge clk); start = 0;
    chk("mtlo busy", 32'(busy), 0);
    chk("mtlo done", 32'(done), 0);
    chk("mtlo hi", hi, 32'h1234);
    chk("mtlo lo", lo, 32'h5678);

    @(negedge clk); op = MDU_MULTU; opr1 = 6; opr2 = 7; start = 1;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    op = MDU_DIVU; opr1 = 100; opr2 = 3; start = 1;
    @(negedge clk); start = 0;
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    chk("ignored start done", 32'(done), 1);
    chk("ignored start hi", hi, 0);
    chk("ignored start lo", lo, 42);

    mt(MDU_MTHI, 32'hAAAA);
    mt(MDU_MTLO, 32'hBBBB);
    @(negedge clk); op = MDU_DIVU; opr1 = 100; opr2 = 3; start = 1;
    @(negedge clk); start = 0;
    repeat (10) @(negedge clk);
    cancel = 1;
    @(negedge clk); cancel = 0;
    chk("cancel busy", 32'(busy), 0);
    chk("cancel done", 32'(done), 0);
    begin
      int pulses = 0;
      repeat (40) begin @(negedge clk); if (done) pulses++; end
      chk("cancel no done", 32'(pulses), 0);
    end
    chk("cancel hi", hi, 32'hAAAA);
    chk("cancel lo", lo, 32'hBBBB);
    run_op(MDU_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "after cancel");

    @(negedge clk); op = MDU_MTHI; opr1 = 32'hDEAD; start = 1; cancel = 1;
    @(negedge clk); op = MDU_MULT; opr1 = 3; opr2 = 3;
    chk("idle cancel mthi hi", hi, 0);
    @(negedge clk); start = 0; cancel = 0;
    chk("idle cancel mult busy", 32'(busy), 0);

    @(negedge clk); op = 3'b110; opr1 = 32'hFFFF; start = 1;
    @(negedge clk); op = 3'b111;
    @(negedge clk); start = 0;
    chk("reserved busy", 32'(busy), 0);
    chk("reserved hi", hi, 0);
    chk("reserved lo", lo, 42);

    @(negedge clk); op = MDU_MULTU; opr1 = 32'hFFFF; opr2 = 32'hFFFF; start = 1;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("async reset busy", 32'(busy), 0);
    chk("async reset hi", hi, 0);
    chk("async reset lo", lo, 0);
    reset = 0;
    run_op(MDU_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, "after reset div -100/7");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
